// File: rtl/tick_pkg.sv
// Shared types and constants for the tick scheduler: detector state encoding,
// event record layout and default channel/counter sizing.
package tick_pkg;

  localparam int N_CH_DEF  = 4;
  localparam int CNT_W_DEF = 8;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] HIGH = 2'b01;
  localparam logic [1:0] LOW  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_HIGH = HIGH,
    ST_LOW  = LOW
  } det_state_e;

  typedef struct packed {
    logic [$clog2(N_CH_DEF)-1:0] ch;
    logic [CNT_W_DEF-1:0]        count;
    logic                        ovf;
  } evt_rec_t;

endpackage

// File: rtl/level_pattern_det.sv
// Detects high / exactly-one-low / high on one level input; tick is combinational
// in the cycle the second high arrives. No backpressure.
module level_pattern_det
  import tick_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic level,
  input  logic enable,
  output logic tick
);

  det_state_e state, state_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = ST_IDLE;
    tick      = 1'b0;
    if (enable) begin
      case (state)
        ST_IDLE: state_nxt = level ? ST_HIGH : ST_IDLE;
        ST_HIGH: state_nxt = level ? ST_HIGH : ST_LOW;
        ST_LOW: begin
          state_nxt = level ? ST_HIGH : ST_IDLE;
          tick      = level;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// Per-channel pattern detectors feed saturating pending counters; a round-robin
// arbiter loads one registered record per free output slot (valid/ready).
module tick_scheduler
  import tick_pkg::*;
#(
  parameter  int N_CH  = N_CH_DEF,
  parameter  int CNT_W = CNT_W_DEF,
  localparam int ID_W  = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_CH-1:0]  level,
  input  logic [N_CH-1:0]  enable,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [ID_W-1:0]  evt_ch,
  output logic [CNT_W-1:0] evt_count,
  output logic             evt_ovf
);

  typedef struct packed {
    logic [ID_W-1:0]  ch;
    logic [CNT_W-1:0] count;
    logic             ovf;
  } rec_t;

  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  logic [N_CH-1:0]  tick;
  logic [CNT_W-1:0] pend [N_CH];
  logic [N_CH-1:0]  ovf;
  logic [ID_W-1:0]  ptr, gnt_idx, cand, ptr_nxt;
  logic             gnt_hit, out_free, out_vld;
  rec_t             out_rec;

  for (genvar g = 0; g < N_CH; g++) begin : g_det
    level_pattern_det u_det (
      .clk    (clk),
      .reset  (reset),
      .level  (level[g]),
      .enable (enable[g]),
      .tick   (tick[g])
    );
  end

  assign out_free = !out_vld || evt_ready;

  always_comb begin
    gnt_hit = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < N_CH; k++) begin
      cand = ID_W'((int'(ptr) + k) % N_CH);
      if (!gnt_hit && pend[cand] != '0) begin
        gnt_hit = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign ptr_nxt = (gnt_idx == ID_W'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;

  // A tick landing on the grant edge restarts the counter at 1 instead of being folded in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_CH; i++) pend[i] <= '0;
      ovf <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (out_free && gnt_hit && gnt_idx == ID_W'(i)) begin
          pend[i] <= CNT_W'(tick[i]);
          ovf[i]  <= 1'b0;
        end else if (tick[i]) begin
          if (pend[i] == PEND_MAX) ovf[i] <= 1'b1;
          else                     pend[i] <= pend[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_vld <= 1'b0;
      out_rec <= '0;
      ptr     <= '0;
    end else if (out_free) begin
      if (gnt_hit) begin
        out_vld <= 1'b1;
        out_rec <= '{ch: gnt_idx, count: pend[gnt_idx], ovf: ovf[gnt_idx]};
        ptr     <= ptr_nxt;
      end else begin
        out_vld <= 1'b0;
      end
    end
  end

  assign evt_valid = out_vld;
  assign evt_ch    = out_rec.ch;
  assign evt_count = out_rec.count;
  assign evt_ovf   = out_rec.ovf;

endmodule

// File: tb/tb_tick_scheduler.sv
// Randomised and directed stimulus for tick_scheduler, checked by a scoreboard fed
// from a history-based reference model.
module tb_tick_scheduler;

  localparam int N    = 4;
  localparam int PMAX = 255;

  logic         clk;
  logic         reset;
  logic [N-1:0] level;
  logic [N-1:0] enable;
  logic         evt_valid;
  logic         evt_ready;
  logic [1:0]   evt_ch;
  logic [7:0]   evt_count;
  logic         evt_ovf;

  tick_scheduler #(.N_CH(N), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .level     (level),
    .enable    (enable),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .evt_count (evt_count),
    .evt_ovf   (evt_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  typedef struct {
    int ch;
    int cnt;
    int ovf;
  } rec_t;

  rec_t exp_q[$];
  rec_t acc_q[$];
  rec_t e;

  // Reference model: a tick is a (1,0,1) level history with the channel enabled
  // for all three cycles; pending events are plain integer counts.
  int m_pend [N];
  int m_ovf  [N];
  int m_ptr;
  int m_valid;
  int m_g;
  int m_c;
  bit m_tick [N];
  bit h_lv1 [N];
  bit h_lv2 [N];
  bit h_en1 [N];
  bit h_en2 [N];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0;
        m_ovf[i]  = 0;
        h_lv1[i]  = 0;
        h_lv2[i]  = 0;
        h_en1[i]  = 0;
        h_en2[i]  = 0;
      end
      m_ptr   = 0;
      m_valid = 0;
      exp_q.delete();
    end else begin
      for (int i = 0; i < N; i++)
        m_tick[i] = enable[i] && level[i] && h_en1[i] && !h_lv1[i] && h_en2[i] && h_lv2[i];
      m_g = -1;
      if (m_valid == 0 || evt_ready) begin
        for (int k = 0; k < N; k++) begin
          m_c = (m_ptr + k) % N;
          if (m_g < 0 && m_pend[m_c] > 0) m_g = m_c;
        end
        if (m_g >= 0) begin
          exp_q.push_back('{m_g, m_pend[m_g], m_ovf[m_g]});
          m_valid = 1;
          m_ptr   = (m_g + 1) % N;
        end else begin
          m_valid = 0;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (i == m_g) begin
          m_pend[i] = m_tick[i] ? 1 : 0;
          m_ovf[i]  = 0;
        end else if (m_tick[i]) begin
          if (m_pend[i] == PMAX) m_ovf[i] = 1;
          else                   m_pend[i] = m_pend[i] + 1;
        end
        h_lv2[i] = h_lv1[i];
        h_en2[i] = h_en1[i];
        h_lv1[i] = level[i];
        h_en1[i] = enable[i];
      end
    end
  end

  always @(negedge clk) begin
    chk("evt_valid", int'(evt_valid), m_valid);
    if (!reset) begin
      chk("rst_ch", int'(evt_ch), 0);
      chk("rst_count", int'(evt_count), 0);
      chk("rst_ovf", int'(evt_ovf), 0);
    end else if (evt_valid && evt_ready) begin
      acc_q.push_back('{int'(evt_ch), int'(evt_count), int'(evt_ovf)});
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_record actual_ch=%0d actual_count=%0d expected=none",
                 evt_ch, evt_count);
      end else begin
        e = exp_q.pop_front();
        chk("rec_ch", int'(evt_ch), e.ch);
        chk("rec_count", int'(evt_count), e.cnt);
        chk("rec_ovf", int'(evt_ovf), e.ovf);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int exp_ch [6] = '{0, 1, 2, 3, 0, 3};
  int exp_gt [3] = '{1, 3, 1};

  initial begin
    level     = '0;
    enable    = '1;
    evt_ready = 1'b1;
    reset     = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // single tick on channel 0
    level = 4'b0001; cyc();
    level = 4'b0000; cyc();
    level = 4'b0001; cyc();
    level = 4'b0000; cyc();
    chk("first_valid", int'(evt_valid), 1);
    chk("first_ch", int'(evt_ch), 0);
    chk("first_count", int'(evt_count), 1);
    chk("first_ovf", int'(evt_ovf), 0);
    cyc();

    // two low cycles: no tick
    acc_q.delete();
    level = 4'b0010; cyc();
    level = 4'b0000; cyc();
    cyc();
    level = 4'b0010; cyc();
    level = 4'b0000;
    repeat (4) cyc();
    chk("long_low_records", acc_q.size(), 0);
    chk("long_low_valid", int'(evt_valid), 0);

    // all channels tick together from ptr=0, then repeat on 3 and 0
    reset = 1'b0; cyc();
    reset = 1'b1;
    acc_q.delete();
    level = 4'b1111; cyc();
    level = 4'b0000; cyc();
    level = 4'b1111; cyc();
    level = 4'b0000;
    repeat (6) cyc();
    level = 4'b1001; cyc();
    level = 4'b0000; cyc();
    level = 4'b1001; cyc();
    level = 4'b0000;
    repeat (5) cyc();
    chk("rr_records", acc_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < acc_q.size()) begin
        chk("rr_order_ch", acc_q[i].ch, exp_ch[i]);
        chk("rr_count", acc_q[i].cnt, 1);
      end
    end

    // saturation on channel 2 while the consumer stalls
    acc_q.delete();
    evt_ready = 1'b0;
    repeat (301) begin
      level = 4'b0100; cyc();
      level = 4'b0000; cyc();
    end
    evt_ready = 1'b1;
    repeat (6) cyc();
    chk("sat_records", acc_q.size(), 2);
    if (acc_q.size() == 2) begin
      chk("sat_ch", acc_q[1].ch, 2);
      chk("sat_count", acc_q[1].cnt, 255);
      chk("sat_ovf", acc_q[1].ovf, 1);
    end
    acc_q.delete();
    level = 4'b0100; cyc();
    level = 4'b0000; cyc();
    level = 4'b0100; cyc();
    level = 4'b0000;
    repeat (4) cyc();
    chk("post_sat_records", acc_q.size(), 1);
    if (acc_q.size() == 1) begin
      chk("post_sat_ovf", acc_q[0].ovf, 0);
      chk("post_sat_count", acc_q[0].cnt, 1);
    end

    // tick on channel 0 in the very cycle it is granted with pend=3
    acc_q.delete();
    evt_ready = 1'b0;
    for (int j = 0; j < 10; j++) begin
      level = (j % 2 == 0) ? 4'b0001 : 4'b0000;
      cyc();
    end
    level     = 4'b0001;
    evt_ready = 1'b1;
    cyc();
    level = 4'b0000;
    repeat (4) cyc();
    chk("grant_tick_records", acc_q.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < acc_q.size()) chk("grant_tick_count", acc_q[i].cnt, exp_gt[i]);

    // asynchronous reset with a record held and events pending
    acc_q.delete();
    evt_ready = 1'b0;
    level = 4'b0010; cyc();
    level = 4'b0000; cyc();
    level = 4'b0010; cyc();
    level = 4'b0000; cyc();
    level = 4'b0010; cyc();
    level = 4'b0000; cyc();
    chk("pre_arst_valid", int'(evt_valid), 1);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("arst_valid", int'(evt_valid), 0);
    chk("arst_ch", int'(evt_ch), 0);
    chk("arst_count", int'(evt_count), 0);
    chk("arst_ovf", int'(evt_ovf), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    evt_ready = 1'b1;
    repeat (5) cyc();
    chk("post_arst_records", acc_q.size(), 0);

    // randomised traffic
    repeat (1500) begin
      level     = 4'($urandom);
      enable    = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b1111;
      evt_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end

    level     = '0;
    enable    = '1;
    evt_ready = 1'b1;
    repeat (20) cyc();
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_valid", int'(evt_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Multi-channel pulse-pattern event scheduler. It runs one pattern detector per `level` input and counts detected events per channel in saturating pending counters. A round-robin arbiter delivers one event record per handshake to a single downstream consumer. It sits between the raw level inputs and the control logic, so one consumer can serve all channels without missing events.

## Interface
- `N_CH`, 4: number of level channels (2..16)
- `CNT_W`, 8: pending-counter and `evt_count` width
- `ID_W`, $clog2(N_CH): channel index width (derived, not overridden)

Ports:
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `level`  in  N_CH  per-channel level, synchronous to `clk`
- `enable`  in  N_CH  per-channel detector enable
- `evt_valid`  out  1  event record available
- `evt_ready`  in  1  consumer accepts record
- `evt_ch`  out  ID_W  channel index of record
- `evt_count`  out  CNT_W  events accumulated on that channel
- `evt_ovf`  out  1  that channel's counter saturated since its last grant

## Operation
- Detector per channel, states IDLE/HIGH/LOW (registered):
  - IDLE: `level`=1 -> HIGH.
  - HIGH: `level`=0 -> LOW.
  - LOW: `level`=1 -> HIGH with `tick`=1 (combinational, this cycle only); `level`=0 -> IDLE.
  - A tick therefore marks high, exactly one low cycle, then high again.
  - Illegal state encoding -> IDLE, no tick.
- `enable[i]`=0 forces detector i to IDLE and suppresses its tick. Existing pending count is kept and still delivered.
- Pending counter `pend[i]`:
  - +1 on each edge where `tick[i]`=1.
  - Saturates at 2^CNT_W-1. A tick arriving at saturation sets sticky `ovf[i]`.
- Output stage is a register holding {ch, count, ovf}.
  - It is free when `evt_valid`=0, or when `evt_valid`=1 and `evt_ready`=1 at this edge.
- Arbiter, when the output stage is free:
  - Scans channels with `pend`>0, starting at `ptr` and wrapping modulo N_CH.
  - Loads the first hit: count=`pend[i]`, ovf=`ovf[i]`.
  - Sets `evt_valid`=1 and `ptr`=i+1 mod N_CH.
  - On a grant edge, `pend[i]` becomes `tick[i]` (0 or 1) and `ovf[i]` clears. A tick on the grant cycle is never lost and never counted in the granted record.
- Nothing pending when free -> `evt_valid`=0; payload holds its last value.
- `evt_valid`=1 with `evt_ready`=0 -> payload stable; pending counters keep accumulating.

## Timing
- Reset (async assert, release sync to `clk`):
  - Detectors IDLE, all `pend`/`ovf` 0, `ptr`=0.
  - `evt_valid`=0, `evt_ch`=0, `evt_count`=0, `evt_ovf`=0.
- Reset mid-operation discards all pending events and any record in the output stage.
- Latency:
  - Tick at edge E -> `pend`=1 after E.
  - `evt_valid` rises after E+1 if the output stage is free.
- Throughput: one record per cycle while `evt_ready`=1; back-to-back grants with no bubble.
- `evt_ready` is ignored while `evt_valid`=0.
- Fairness: a channel with `pend`>0 is granted within N_CH accepted records.
- All outputs are registered; no combinational path from `level` or `evt_ready` to any output.

## Structure
- Shared package `tick_pkg` holds:
  - State encoding localparams IDLE=2'b00, HIGH=2'b01, LOW=2'b10.
  - Record type {ch, count, ovf} as a packed struct.
  - Default N_CH/CNT_W constants.
- Sub-module `level_pattern_det` (clk, reset, level, enable -> tick), instantiated N_CH times via generate.
- Arbiter scan and pending counters live in the top.
- Target size: 200-300 lines total.

## Test plan
- Reset, `level`=0, then channel 0 drives 1,0,1 on consecutive cycles -> one tick. Two edges later `evt_valid`=1, `evt_ch`=0, `evt_count`=1, `evt_ovf`=0.
- Channel 1 drives 1,0,0,1 (low held two cycles) -> no tick, `evt_valid` stays 0.
- Channels 0..3 each produce one tick in the same cycle, `evt_ready`=1 -> records for channels 0,1,2,3 on four consecutive cycles. A repeat on channels 3 and 0 then grants 0 first (`ptr` wrapped).
- `evt_ready`=0, CNT_W=8, channel 2 produces 300 ticks, then `evt_ready`=1 -> `evt_count`=255, `evt_ovf`=1. The next channel-2 record has `evt_ovf`=0.
- Tick on channel 0 in the same cycle it is granted with `pend`=3 -> record count=3, then a second record with count=1.
- Assert `reset` low asynchronously while `evt_valid`=1 and `pend` is nonzero -> all outputs 0 immediately. After release, no record until a new tick.
